// File: rtl/ex_result_skid.sv
// Execute-to-memory boundary register with a 2-entry skid buffer and registered upstream ready.
// Optional stall-cycle counter on oStallCnt is enabled by defining EX_RESULT_STALL_CNT_EN.
module ex_result_skid #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic              iValid,
    output logic              oReady,
    input  logic [DATA_W-1:0] iAluData,
    input  logic              iAluZero,
    input  logic [RD_W-1:0]   iRd,
    input  logic              iRegWrite,
    input  logic              iFlush,
    output logic              oValid,
    input  logic              iReady,
    output logic [DATA_W-1:0] oData,
    output logic              oZero,
    output logic [RD_W-1:0]   oRd,
    output logic              oRegWrite,
    output logic [CNT_W-1:0]  oStallCnt
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              zero;
        logic [RD_W-1:0]   rd;
        logic              regwrite;
    } beat_t;

    // State bits are literally {M.valid, S.valid}; 2'b01 cannot be reached.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t state, state_nxt;
    beat_t  m_q, s_q, in_beat;
    logic   m_valid, s_valid;
    logic   up_xfer, dn_xfer;
    logic   load_m_in, load_m_skid, load_s;

    assign m_valid = state[1];
    assign s_valid = state[0];

    // Ready depends only on the state flop, so iReady never reaches oReady combinationally.
    assign oReady  = !s_valid;
    assign oValid  = m_valid;
    assign up_xfer = iValid && oReady;
    assign dn_xfer = oValid && iReady;

    // x0 writes are squashed once, at capture, so downstream never sees them.
    always_comb begin
        in_beat.data     = iAluData;
        in_beat.zero     = iAluZero;
        in_beat.rd       = iRd;
        in_beat.regwrite = iRegWrite && (iRd != '0);
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        load_m_in   = 1'b0;
        load_m_skid = 1'b0;
        load_s      = 1'b0;
        if (iFlush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (up_xfer) begin
                        load_m_in = 1'b1;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (up_xfer && dn_xfer) begin
                        load_m_in = 1'b1;
                    end else if (up_xfer) begin
                        load_s    = 1'b1;
                        state_nxt = FULL;
                    end else if (dn_xfer) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (dn_xfer) begin
                        load_m_skid = 1'b1;
                        state_nxt   = ONE;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // M drives the outputs directly, so it has defined reset contents.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            m_q <= '0;
        end else if (load_m_in) begin
            m_q <= in_beat;
        end else if (load_m_skid) begin
            m_q <= s_q;
        end
    end

    // NOTE: skid data is never observed while S.valid is low, so it carries no reset.
    always_ff @(posedge iClk) begin
        if (load_s) begin
            s_q <= in_beat;
        end
    end

    assign oData     = m_q.data;
    assign oZero     = m_q.zero;
    assign oRd       = m_q.rd;
    assign oRegWrite = m_q.regwrite;

`ifdef EX_RESULT_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q;

    // Saturating count of cycles the consumer held off a valid beat; flush leaves it alone.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            stall_q <= '0;
        end else if (oValid && !iReady && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign oStallCnt = stall_q;
`else
    assign oStallCnt = '0;
`endif

endmodule

// File: tb/tb_ex_result_skid.sv
// Scoreboard bench for ex_result_skid: a queue model of the buffer predicts every output beat.
// Stall-counter expectations follow EX_RESULT_STALL_CNT_EN when it is defined for the build.
module tb_ex_result_skid;

    typedef struct packed {
        logic [31:0] data;
        logic        zero;
        logic [4:0]  rd;
        logic        rw;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_data = '0;
    logic        i_zero = 1'b0;
    logic [4:0]  i_rd = '0;
    logic        i_rw = 1'b0;
    logic        i_flush = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_data;
    logic        o_zero;
    logic [4:0]  o_rd;
    logic        o_rw;
    logic [15:0] o_stall;

    ex_result_skid dut (
        .iClk(clk), .iRstN(rst_n), .iValid(i_valid), .oReady(o_ready),
        .iAluData(i_data), .iAluZero(i_zero), .iRd(i_rd), .iRegWrite(i_rw),
        .iFlush(i_flush), .oValid(o_valid), .iReady(i_ready), .oData(o_data),
        .oZero(o_zero), .oRd(o_rd), .oRegWrite(o_rw), .oStallCnt(o_stall)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: beats held by the stage, oldest first (at most two).
    beat_t exp_q[$];
    beat_t p_beat;
    beat_t e_mon;
    logic  p_acc = 1'b0;
    logic  p_flush = 1'b0;
    logic  checking = 1'b0;
    logic [15:0] stall_model = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock: commit the previous cycle's effect on the model, then drive this cycle.
    task automatic step(input logic v, input logic [31:0] d, input logic z,
                        input logic [4:0] rd, input logic rw, input logic rdy,
                        input logic fl);
        @(posedge clk);
        #1;
        if (p_flush) exp_q.delete();
        if (p_acc) exp_q.push_back(p_beat);
        i_valid = v;
        i_data  = d;
        i_zero  = z;
        i_rd    = rd;
        i_rw    = rw;
        i_ready = rdy;
        i_flush = fl;
        p_flush = fl;
        p_acc   = v && (exp_q.size() < 2) && !fl;
        p_beat  = '{data: d, zero: z, rd: rd, rw: rw && (rd != 5'd0)};
        checking = 1'b1;
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, rdy, 1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, o_valid, 1'b0);
        check({tag, "_data"}, o_data, 32'h0);
        check({tag, "_zero"}, o_zero, 1'b0);
        check({tag, "_rd"}, o_rd, 5'd0);
        check({tag, "_rw"}, o_rw, 1'b0);
        check({tag, "_ready"}, o_ready, 1'b1);
        check({tag, "_stall"}, o_stall, 16'h0);
    endtask

    // Reset mid-cycle: outputs must clear before any further clock edge.
    task automatic async_reset();
        @(posedge clk);
        #2;
        checking = 1'b0;
        i_valid = 1'b0;
        i_flush = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        exp_q.delete();
        p_acc = 1'b0;
        p_flush = 1'b0;
        stall_model = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compares the presented beat with the model head every cycle.
    always @(negedge clk) begin
        if (checking) begin
            check("ready", o_ready, exp_q.size() < 2);
            check("valid", o_valid, exp_q.size() > 0);
            check("stall_cnt", o_stall, stall_model);
            if (o_valid && exp_q.size() > 0) begin
                e_mon = exp_q[0];
                check("data", o_data, e_mon.data);
                check("zero", o_zero, e_mon.zero);
                check("rd", o_rd, e_mon.rd);
                check("regwrite", o_rw, e_mon.rw);
                if (i_ready) void'(exp_q.pop_front());
            end
`ifdef EX_RESULT_STALL_CNT_EN
            if (o_valid && !i_ready && stall_model != 16'hFFFF) stall_model = stall_model + 16'd1;
`endif
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_vals("post_reset");

        // Single beat, then the stage empties again.
        step(1'b1, 32'hDEADBEEF, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        idle(1'b1, 3);

        // Eight back-to-back beats at full rate.
        for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 1'b0, 5'(i + 2), 1'b1, 1'b1, 1'b0);
        idle(1'b1, 3);

        // Backpressure fills the skid entry, then drains in order.
        step(1'b1, 32'h11, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h22, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h33, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        idle(1'b0, 2);
        idle(1'b1, 4);

        // Write to x0 is squashed; zero flag passes through.
        step(1'b1, 32'h0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
        idle(1'b1, 2);

        // Flush while full with a new beat offered.
        step(1'b1, 32'hA0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'hB0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'hC0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1);
        idle(1'b1, 3);

        // Five stall cycles on a held beat, then reset mid-stall.
        step(1'b1, 32'h55, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        idle(1'b0, 5);
        async_reset();
        idle(1'b1, 2);

        // Randomized traffic with occasional flushes and x0 destinations.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, $urandom, 1'($urandom), (($urandom % 4) == 0) ? 5'd0 : 5'($urandom),
                 1'($urandom), ($urandom % 3) != 0, ($urandom % 25) == 0);
        end

        // Bounded drain.
        for (int i = 0; i < 10 && (exp_q.size() != 0 || p_acc); i++) idle(1'b1, 1);
        idle(1'b1, 1);
        @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_result_skid.md
Name: ex_result_skid

Overview:
- Registered execute-to-memory boundary stage. Sits directly downstream of the combinational ALU.
- Captures the ALU result (oData, oZero) together with the destination register tag and write-enable.
- Presents them to the memory/writeback stage through a valid/ready handshake.
- A 2-entry skid buffer keeps full throughput under downstream backpressure, because the upstream ready output is registered and breaks the combinational ready path.

Parameters:
- DATA_W, 32, width of ALU result and output data.
- RD_W, 5, width of destination register index.
- CNT_W, 16, width of stall counter (used only with the optional feature).

Ports:
- iClk  input  1  clock, all state on rising edge.
- iRstN  input  1  asynchronous active-low reset.
- iValid  input  1  upstream beat valid.
- oReady  output  1  stage can accept a beat this cycle.
- iAluData  input  DATA_W  ALU result (oData of ALU).
- iAluZero  input  1  ALU zero flag (oZero of ALU).
- iRd  input  RD_W  destination register index.
- iRegWrite  input  1  beat writes the register file.
- iFlush  input  1  synchronous pipeline flush.
- oValid  output  1  downstream beat valid.
- iReady  input  1  downstream accepts beat.
- oData  output  DATA_W  registered result.
- oZero  output  1  registered zero flag.
- oRd  output  RD_W  registered destination index.
- oRegWrite  output  1  registered write-enable, qualified.
- oStallCnt  output  CNT_W  stall cycle count (optional feature only).

Behaviour:
- Clock and reset: one clock, iClk. Reset iRstN is asynchronous and active-low.
- Reset values: oValid=0, oData=0, oZero=0, oRd=0, oRegWrite=0, skid entry empty, oReady=1 from the first cycle after reset release.
- Storage: main register M (drives outputs) and skid register S. Both hold {data, zero, rd, regwrite} plus a valid bit.
- Upstream transfer: iValid && oReady. Downstream transfer: oValid && iReady.
- oReady = !S.valid. This is purely registered, with no combinational path from iReady.
- Latency: 1 cycle. A beat accepted at edge N appears on the outputs after edge N when M is free or draining.
- State machine, encoded by {M.valid, S.valid}:
  - EMPTY (0,0): accept loads M → ONE.
  - ONE (1,0):
    - Accept with drain: load M → ONE.
    - Accept without drain: load S → FULL.
    - Drain without accept → EMPTY.
    - Neither: hold.
  - FULL (1,1): oReady=0.
    - Drain moves S→M → ONE.
    - Otherwise hold.
  - (0,1) is illegal and unreachable.
- Ordering: strict FIFO. The S contents always follow the M contents.
- Hold rule: while oValid=1 and iReady=0, all output fields stay stable.
- Write qualification: oRegWrite is forced to 0 when the captured rd==0 (x0 write suppression). The qualification is applied at capture time.
- Flush: iFlush=1 at an edge clears M.valid and S.valid, so the next state is EMPTY.
  - An upstream beat presented in the same cycle is discarded.
  - A downstream transfer in the same cycle still completes; the consumer saw it.
  - Data fields are not cleared by flush.
- Reset asserted mid-operation clears all state immediately, independent of the clock. Any buffered beats are lost.
- No data-dependent behaviour: oZero is stored verbatim and not recomputed.

Optional Feature:
- Macro EX_RESULT_STALL_CNT_EN.
- When defined:
  - oStallCnt counts cycles with oValid=1 && iReady=0.
  - It saturates at all-ones, with no wrap.
  - It is reset to 0 by iRstN and is not affected by iFlush.
- When undefined:
  - The port still exists but is tied to 0.
  - No counter flops are present.

Test Plan:
1. Reset then single beat: iAluData=32'hDEADBEEF, iAluZero=0, iRd=5, iRegWrite=1, iReady=1 → one cycle later oValid=1, oData=DEADBEEF, oRd=5, oRegWrite=1. The following cycle oValid=0.
2. Back-to-back stream of 8 beats (data 1..8) with iReady=1 → 8 consecutive output beats in order, oReady never drops.
3. Backpressure: beats A=0x11 and B=0x22 with iReady=0 → after B, oReady=0 and oData holds 0x11. Raise iReady → 0x11 then 0x22 delivered, oReady returns to 1 one cycle after S drains.
4. x0 suppression: iRd=0, iRegWrite=1, iAluData=0, iAluZero=1 → oRegWrite=0, oZero=1, oValid=1.
5. Flush in FULL state with a new beat C presented → next cycle oValid=0 and oReady=1. C never appears at the output.
6. With EX_RESULT_STALL_CNT_EN defined:
   - Hold iReady=0 for 5 cycles while oValid=1 → oStallCnt=5.
   - Assert iRstN=0 mid-stall → all outputs go to their reset values immediately and oStallCnt=0.
